ed25519_sign_s_seq_core: RTL and testbench

ED25519_SIGN_S_SEQ_CORE -- requirements
Module: ed25519_sign_s_seq_core

---
 rtl/ed25519_sign_s_seq_core.sv | 192 +++++++++++++++++++
 tb/tb_ed25519_sign_s_seq_core.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ed25519_sign_s_seq_core.sv
// Ed25519 signature S-value sequencer.
// Computes S = (R + K*A) mod LMOD (IMODE=0) or S = R mod LMOD (IMODE=1)
// using a bit-serial MSB-first reduction of both hashes followed by a
// bit-serial Horner multiply over the secret scalar.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request, OSIGN holds the last result
// RED   | NW steps reducing R and K modulo LMOD in parallel
// MUL   | AW Horner steps computing kred*A modulo LMOD
// FIN   | one step adding rred to the product, registering OSIGN
// DONE  | result valid, waiting for IACK
module ed25519_sign_s_seq_core #(
  parameter int          NW   = 512,
  parameter int          AW   = 253,
  parameter int          LW   = 253,
  parameter logic [LW-1:0] LMOD = 253'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed
) (
  input  logic          ICLK,
  input  logic          IRST_N,
  input  logic          IEN,
  input  logic          IMODE,
  input  logic          IABORT,
  input  logic [NW-1:0] IHASHD_RAM,
  input  logic [NW-1:0] IHASHD_SM,
  input  logic [AW-1:0] IHASHD_KEY,
  input  logic          IACK,
  output logic          OREADY,
  output logic          ODONE,
  output logic [LW-1:0] OSIGN
);

  localparam int CMAX = (NW > AW) ? NW : AW;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int NIW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int AIW  = (AW > 1) ? $clog2(AW) : 1;

  localparam logic [CW-1:0] C_RED_LAST = CW'(NW - 1);
  localparam logic [CW-1:0] C_MUL_LAST = CW'(AW - 1);
  localparam logic [LW:0]   L1 = {1'b0, LMOD};
  localparam logic [LW+1:0] L2 = {2'b00, LMOD};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RED,
    S_MUL,
    S_FIN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_mode;
  logic [NW-1:0]   r_hr;
  logic [NW-1:0]   r_hk;
  logic [AW-1:0]   r_a;
  logic [LW-1:0]   r_rred;
  logic [LW-1:0]   r_kred;
  logic [LW-1:0]   r_acc;
  logic [LW-1:0]   r_osign;

  logic            w_accept;
  logic            w_abort;
  logic            w_cnt_zero;
  logic            w_hr_bit;
  logic            w_hk_bit;
  logic            w_a_bit;
  logic [LW:0]     w_rx;
  logic [LW:0]     w_kx;
  logic [LW-1:0]   w_rred_nxt;
  logic [LW-1:0]   w_kred_nxt;
  logic [LW+1:0]   w_t;
  logic [LW+1:0]   w_t1;
  logic [LW-1:0]   w_acc_nxt;
  logic [LW:0]     w_f;
  logic [LW-1:0]   w_fin;

  // Next-state and status outputs; abort overrides every busy state.
  always_comb begin
    w_state_nxt = r_state;
    OREADY      = 1'b0;
    ODONE       = 1'b0;
    w_accept    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        OREADY   = 1'b1;
        w_accept = IEN && !IABORT;
        if (w_accept) w_state_nxt = S_RED;
      end
      S_RED:  if (w_cnt_zero) w_state_nxt = r_mode ? S_DONE : S_MUL;
      S_MUL:  if (w_cnt_zero) w_state_nxt = S_FIN;
      S_FIN:  w_state_nxt = S_DONE;
      S_DONE: begin
        ODONE = 1'b1;
        if (IACK) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (IABORT && (r_state != S_IDLE)) begin
      w_abort     = 1'b1;
      w_state_nxt = S_IDLE;
    end
  end

  // State register.
  always_ff @(posedge ICLK or negedge IRST_N) begin
    if (!IRST_N) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Modular step arithmetic: one reduction bit, one Horner bit, final add.
  always_comb begin
    w_cnt_zero = (r_cnt == '0);
    w_hr_bit   = r_hr[r_cnt[NIW-1:0]];
    w_hk_bit   = r_hk[r_cnt[NIW-1:0]];
    w_a_bit    = r_a[r_cnt[AIW-1:0]];

    w_rx       = {r_rred, w_hr_bit};
    w_kx       = {r_kred, w_hk_bit};
    w_rred_nxt = (w_rx >= L1) ? LW'(w_rx - L1) : LW'(w_rx);
    w_kred_nxt = (w_kx >= L1) ? LW'(w_kx - L1) : LW'(w_kx);

    // 2*acc + kred < 3*LMOD, so two conditional subtractions suffice.
    w_t        = {1'b0, r_acc, 1'b0} + {2'b00, (w_a_bit ? r_kred : {LW{1'b0}})};
    w_t1       = (w_t >= L2) ? (w_t - L2) : w_t;
    w_acc_nxt  = (w_t1 >= L2) ? LW'(w_t1 - L2) : LW'(w_t1);

    w_f        = {1'b0, r_acc} + {1'b0, r_rred};
    w_fin      = (w_f >= L1) ? LW'(w_f - L1) : LW'(w_f);
  end

  // Operand capture, step counter and accumulators.
  always_ff @(posedge ICLK or negedge IRST_N) begin
    if (!IRST_N) begin
      r_cnt   <= '0;
      r_mode  <= 1'b0;
      r_hr    <= '0;
      r_hk    <= '0;
      r_a     <= '0;
      r_rred  <= '0;
      r_kred  <= '0;
      r_acc   <= '0;
      r_osign <= '0;
    end else if (w_abort) begin
      r_cnt   <= '0;
      r_mode  <= 1'b0;
      r_hr    <= '0;
      r_hk    <= '0;
      r_a     <= '0;
      r_rred  <= '0;
      r_kred  <= '0;
      r_acc   <= '0;
      r_osign <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mode <= IMODE;
            r_hr   <= IHASHD_RAM;
            r_hk   <= IHASHD_SM;
            r_a    <= IHASHD_KEY;
            r_cnt  <= C_RED_LAST;
            r_rred <= '0;
            r_kred <= '0;
            r_acc  <= '0;
          end
        end
        S_RED: begin
          r_rred <= w_rred_nxt;
          r_kred <= w_kred_nxt;
          if (w_cnt_zero) begin
            if (r_mode) r_osign <= w_rred_nxt;
            else        r_cnt   <= C_MUL_LAST;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_MUL: begin
          r_acc <= w_acc_nxt;
          if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;
        end
        S_FIN: r_osign <= w_fin;
        default: ;
      endcase
    end
  end

  assign OSIGN = r_osign;

endmodule

// File: tb/tb_ed25519_sign_s_seq_core.sv
// Scoreboard bench for ed25519_sign_s_seq_core: a default-size instance and a
// small (NW=16, AW=8, LW=8, LMOD=251) instance, each with its own expected
// queue and a negedge monitor that checks result, latency and handshakes.
module tb_ed25519_sign_s_seq_core;

  localparam logic [252:0] L0 = 253'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;

  typedef struct {
    logic [252:0] val;
    int           lat;
    bit           abandon;
  } exp_t;

  logic clk;
  logic rst_n;
  logic en [2];
  logic md [2];
  logic ab [2];
  logic ak [2];

  logic [511:0] r0, k0;
  logic [252:0] a0;
  logic         rdy0, dn0;
  logic [252:0] os0;
  logic [15:0]  r1, k1;
  logic [7:0]   a1;
  logic         rdy1, dn1;
  logic [7:0]   os1;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t q0[$];
  exp_t q1[$];
  bit   m_busy [2];
  bit   m_seen [2];
  bit   m_post [2];
  bit   m_abt  [2];
  int   m_lat  [2];
  exp_t m_cur  [2];

  ed25519_sign_s_seq_core dut0 (
    .ICLK(clk), .IRST_N(rst_n), .IEN(en[0]), .IMODE(md[0]), .IABORT(ab[0]),
    .IHASHD_RAM(r0), .IHASHD_SM(k0), .IHASHD_KEY(a0), .IACK(ak[0]),
    .OREADY(rdy0), .ODONE(dn0), .OSIGN(os0)
  );

  ed25519_sign_s_seq_core #(.NW(16), .AW(8), .LW(8), .LMOD(8'd251)) dut1 (
    .ICLK(clk), .IRST_N(rst_n), .IEN(en[1]), .IMODE(md[1]), .IABORT(ab[1]),
    .IHASHD_RAM(r1), .IHASHD_SM(k1), .IHASHD_KEY(a1), .IACK(ak[1]),
    .OREADY(rdy1), .ODONE(dn1), .OSIGN(os1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain wide-integer arithmetic.
  function automatic logic [252:0] ref_s(input logic mode, input logic [511:0] r, input logic [511:0] k,
                                         input logic [252:0] a, input logic [252:0] l);
    logic [799:0] t;
    if (mode) t = {288'd0, r} % {547'd0, l};
    else      t = ({288'd0, r} + {288'd0, k} * {547'd0, a}) % {547'd0, l};
    return 253'(t);
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] v = '0;
    for (int i = 0; i < 16; i++) v = {v[479:0], 32'($urandom())};
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic mon(input int d, input logic rst, input logic rdy, input logic dn, input logic en_i,
                     input logic ab_i, input logic ak_i, input logic [252:0] os);
    if (m_post[d]) begin
      chk("idle_after_ack", {rdy, dn, os}, {1'b1, 1'b0, m_cur[d].val});
      m_post[d] = 0;
    end else if (m_abt[d]) begin
      chk("idle_after_abort", {rdy, dn, os}, {1'b1, 1'b0, 253'd0});
      m_abt[d] = 0;
    end else if (!m_busy[d] && dn) begin
      chk("spurious_done", dn, 0);
    end
    if (!rst) begin
      if (m_busy[d]) m_abt[d] = 1;
      m_busy[d] = 0;
      return;
    end
    if (m_busy[d]) begin
      m_lat[d]++;
      if (m_cur[d].abandon) begin
        if (dn) chk("done_on_abandoned_op", dn, 0);
      end else if (m_seen[d]) begin
        chk("done_hold", {dn, os}, {1'b1, m_cur[d].val});
      end else if (dn) begin
        chk("latency", m_lat[d], m_cur[d].lat);
        chk("result", os, m_cur[d].val);
        m_seen[d] = 1;
      end else if (m_lat[d] > m_cur[d].lat + 4) begin
        chk("done_timeout", m_lat[d], m_cur[d].lat);
        m_busy[d] = 0;
      end
      if (ab_i) begin
        m_busy[d] = 0;
        m_abt[d]  = 1;
      end else if (m_seen[d] && ak_i) begin
        m_busy[d] = 0;
        m_post[d] = 1;
      end
    end else if (rdy && en_i && !ab_i) begin
      if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
        chk("unexpected_accept", 1, 0);
      end else begin
        if (d == 0) m_cur[d] = q0.pop_front();
        else        m_cur[d] = q1.pop_front();
        m_busy[d] = 1;
        m_lat[d]  = 0;
        m_seen[d] = 0;
      end
    end
  endtask

  // Monitors: the cycle right after the accept edge is latency 1.
  always @(negedge clk) mon(0, rst_n, rdy0, dn0, en[0], ab[0], ak[0], os0);
  always @(negedge clk) mon(1, rst_n, rdy1, dn1, en[1], ab[1], ak[1], {245'd0, os1});

  task automatic issue(input int d, input logic mode, input logic [511:0] r, input logic [511:0] k,
                       input logic [252:0] a, input logic [252:0] ev, input bit abandon);
    exp_t e;
    int   n = 0;
    while (!((d == 0) ? rdy0 : rdy1) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) chk("ready_timeout", n, 0);
    e.val     = ev;
    e.abandon = abandon;
    e.lat     = (d == 0) ? (mode ? 513 : 767) : (mode ? 17 : 26);
    if (d == 0) begin
      q0.push_back(e);
      r0 = r; k0 = k; a0 = a;
    end else begin
      q1.push_back(e);
      r1 = r[15:0]; k1 = k[15:0]; a1 = a[7:0];
    end
    md[d] = mode;
    en[d] = 1'b1;
    @(posedge clk); #1;
    en[d] = 1'b0;
    md[d] = ~mode;
    if (d == 0) begin
      r0 = rnd512(); k0 = rnd512(); a0 = 253'(rnd512());
    end else begin
      r1 = 16'($urandom()); k1 = 16'($urandom()); a1 = 8'($urandom());
    end
  endtask

  task automatic wait_done(input int d);
    int n = 0;
    while (!((d == 0) ? dn0 : dn1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("wait_done_timeout", n, 0);
  endtask

  task automatic finish_op(input int d, input int hold, input bit pulses);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      en[d] = pulses && (i[0] == 1'b0);
    end
    @(posedge clk); #1;
    en[d] = 1'b0;
    ak[d] = 1'b1;
    @(posedge clk); #1;
    ak[d] = 1'b0;
  endtask

  task automatic run_default(input logic mode, input logic [511:0] r, input logic [511:0] k,
                             input logic [252:0] a, input int hold);
    issue(0, mode, r, k, a, ref_s(mode, r, k, a, L0), 0);
    wait_done(0);
    finish_op(0, hold, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] r, k;
    logic [252:0] a;
    logic         m;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      en[d] = 0; md[d] = 0; ab[d] = 0; ak[d] = 0;
    end
    r0 = '0; k0 = '0; a0 = '0; r1 = '0; k1 = '0; a1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_default", {rdy0, dn0, os0}, {1'b1, 1'b0, 253'd0});
    chk("reset_outputs_small", {rdy1, dn1, os1}, {1'b1, 1'b0, 8'd0});
    rst_n = 1'b1;

    // Small instance: reference vectors, accepted on the first edge after reset.
    issue(1, 1'b0, 512'hFFFF, 512'h0102, 253'hFF, 253'd52, 0);
    wait_done(1);
    finish_op(1, 10, 1);
    issue(1, 1'b1, 512'hFFFF, 512'h1234, 253'h5A, 253'd24, 0);
    wait_done(1);
    finish_op(1, 0, 0);

    for (int i = 0; i < 24; i++) begin
      r = {496'd0, 16'($urandom())};
      k = {496'd0, 16'($urandom())};
      a = {245'd0, 8'($urandom())};
      m = 1'($urandom_range(0, 1));
      issue(1, m, r, k, a, ref_s(m, r, k, a, 253'd251), 0);
      wait_done(1);
      finish_op(1, $urandom_range(0, 3), 1);
    end

    // Default instance: boundary values.
    issue(0, 1'b0, {259'd0, L0}, 512'd1, 253'd1, 253'd1, 0);
    wait_done(0);
    finish_op(0, 0, 0);
    a = 253'(rnd512());
    issue(0, 1'b0, 512'd0, 512'd0, a, 253'd0, 0);
    wait_done(0);
    finish_op(0, 0, 0);
    run_default(1'b0, '1, '1, '1, 1);
    run_default(1'b1, '1, rnd512(), 253'(rnd512()), 0);

    // Abort during MUL, with IEN and IACK asserted on the same edge.
    issue(0, 1'b0, rnd512(), rnd512(), 253'(rnd512()), 253'd0, 1);
    repeat (600) @(posedge clk);
    #1;
    ab[0] = 1; en[0] = 1; ak[0] = 1;
    @(posedge clk); #1;
    ab[0] = 0; en[0] = 0; ak[0] = 0;
    run_default(1'b0, rnd512(), rnd512(), 253'(rnd512()), 0);

    // Abort in IDLE blocks a simultaneous request.
    en[0] = 1; ab[0] = 1;
    @(posedge clk); #1;
    en[0] = 0; ab[0] = 0;
    chk("idle_abort_no_accept", rdy0, 1);

    // Reset during RED.
    issue(0, 1'b0, rnd512(), rnd512(), 253'(rnd512()), 253'd0, 1);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {rdy0, dn0, os0}, {1'b1, 1'b0, 253'd0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_default(1'b0, rnd512(), rnd512(), 253'(rnd512()), 0);

    // Abort in DONE outranks IACK.
    r = rnd512(); k = rnd512(); a = 253'(rnd512());
    issue(0, 1'b0, r, k, a, ref_s(1'b0, r, k, a, L0), 0);
    wait_done(0);
    @(posedge clk); #1;
    ab[0] = 1; ak[0] = 1;
    @(posedge clk); #1;
    ab[0] = 0; ak[0] = 0;

    for (int i = 0; i < 8; i++) begin
      run_default(1'($urandom_range(0, 1)), rnd512(), rnd512(), 253'(rnd512()), $urandom_range(0, 2));
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
